// File: rtl/cpuy_seq_pkg.sv
// Shared types and constants for the cpuy instruction sequencer.
package cpuy_seq_pkg;

  // The high (second) writeback byte is a sub-phase of StWb, tracked by a flag,
  // so that all states fit in the 3-bit debug encoding.
  typedef enum logic [2:0] {
    StIdle,
    StFetchOp,
    StFetchArg,
    StDecode,
    StRamRd,
    StExec,
    StWb,
    StHalt
  } seq_state_e;

  localparam logic [7:0] HaltOpcodeDefault = 8'hFF;
  localparam int unsigned InstrLen = 2;

endpackage

// File: rtl/seq_mem_port.sv
// Generic single-outstanding read handshaker: req rises on launch and drops
// after the cycle in which req && ack completes the transfer.
module seq_mem_port #(
  parameter int unsigned AW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          launch,
  input  logic [AW-1:0] launch_addr,
  input  logic          ack,
  input  logic [7:0]    rdata,
  output logic          req,
  output logic [AW-1:0] addr,
  output logic          done,
  output logic [7:0]    data
);

  logic          req_q;
  logic [AW-1:0] addr_q;

  // A launch in the completing cycle re-arms the port for a back-to-back read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q  <= 1'b0;
      addr_q <= '0;
    end else if (launch) begin
      req_q  <= 1'b1;
      addr_q <= launch_addr;
    end else if (done) begin
      req_q  <= 1'b0;
    end
  end

  assign done = req_q & ack;
  assign data = rdata;
  assign req  = req_q;
  assign addr = addr_q;

endmodule

// File: rtl/cpuy_sequencer.sv
// cpuy instruction sequencer: fetches opcode/operand pairs, resolves RAM
// operands, steers the PC and issues ALU and writeback strobes.
module cpuy_sequencer
  import cpuy_seq_pkg::*;
#(
  parameter int unsigned PC_WIDTH    = 8,
  parameter logic [7:0]  HALT_OPCODE = HaltOpcodeDefault
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  output logic                halted,
  output logic                prog_req,
  output logic [PC_WIDTH-1:0] prog_addr,
  input  logic [7:0]          prog_data,
  input  logic                prog_ack,
  output logic                ram_req,
  output logic [7:0]          ram_addr,
  input  logic [7:0]          ram_data,
  input  logic                ram_ack,
  output logic [7:0]          opcode,
  output logic [7:0]          operand,
  input  logic                alu_operation,
  input  logic                alu_multibyte_result,
  input  logic                jump_operation,
  input  logic                jump_condition,
  input  logic                mov_operation,
  input  logic                ram_operand,
  input  logic                duplicate_w,
  output logic                alu_en,
  output logic                wb_en,
  output logic                wb_high,
  output logic [PC_WIDTH-1:0] pc,
  output logic [2:0]          state
);

  localparam logic [PC_WIDTH-1:0] PcOne = PC_WIDTH'(1);

  seq_state_e          state_q, state_d, boundary;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [7:0]          opcode_q, opcode_d, operand_q, operand_d;
  logic                second_q, second_d;
  logic                alu_en_q, wb_en_q, wb_high_q, halted_q;
  logic                prog_launch, prog_done, ram_launch, ram_done;
  logic [7:0]          prog_rdata, ram_rdata;

  // run is only consulted where an instruction ends.
  assign boundary = run ? StFetchOp : StIdle;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    opcode_d  = opcode_q;
    operand_d = operand_q;
    second_d  = 1'b0;
    case (state_q)
      StIdle: if (run) state_d = StFetchOp;
      StFetchOp: begin
        if (prog_done) begin
          opcode_d = prog_rdata;
          pc_d     = pc_q + PcOne;
          state_d  = StFetchArg;
        end
      end
      StFetchArg: begin
        if (prog_done) begin
          operand_d = prog_rdata;
          pc_d      = pc_q + PcOne;
          state_d   = StDecode;
        end
      end
      StDecode: begin
        if (opcode_q == HALT_OPCODE) state_d = StHalt;
        else if (ram_operand)        state_d = StRamRd;
        else                         state_d = StExec;
      end
      StRamRd: begin
        if (ram_done) begin
          operand_d = ram_rdata;
          state_d   = StExec;
        end
      end
      StExec: begin
        if (jump_operation) begin
          if (jump_condition) pc_d = PC_WIDTH'(operand_q);
          state_d = boundary;
        end else if (alu_operation || mov_operation) begin
          state_d = StWb;
        end else begin
          state_d = boundary;
        end
      end
      StWb: begin
        if (!second_q && (alu_multibyte_result || duplicate_w)) second_d = 1'b1;
        else                                                     state_d  = boundary;
      end
      StHalt: state_d = StHalt;
      default: state_d = StIdle;
    endcase
  end

  // Strobes are decoded from the next state so they are registered yet line up
  // with the state they belong to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      pc_q      <= '0;
      opcode_q  <= '0;
      operand_q <= '0;
      second_q  <= 1'b0;
      alu_en_q  <= 1'b0;
      wb_en_q   <= 1'b0;
      wb_high_q <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      opcode_q  <= opcode_d;
      operand_q <= operand_d;
      second_q  <= second_d;
      alu_en_q  <= (state_d == StExec) && alu_operation && !jump_operation;
      wb_en_q   <= (state_d == StWb);
      wb_high_q <= second_d;
      halted_q  <= (state_d == StHalt);
    end
  end

  assign prog_launch = (state_d == StFetchOp || state_d == StFetchArg) && (state_d != state_q);
  assign ram_launch  = (state_d == StRamRd) && (state_q != StRamRd);

  seq_mem_port #(.AW(PC_WIDTH)) u_prog_port (
    .clk         (clk),
    .rst_n       (rst_n),
    .launch      (prog_launch),
    .launch_addr (pc_d),
    .ack         (prog_ack),
    .rdata       (prog_data),
    .req         (prog_req),
    .addr        (prog_addr),
    .done        (prog_done),
    .data        (prog_rdata)
  );

  seq_mem_port #(.AW(8)) u_ram_port (
    .clk         (clk),
    .rst_n       (rst_n),
    .launch      (ram_launch),
    .launch_addr (operand_d),
    .ack         (ram_ack),
    .rdata       (ram_data),
    .req         (ram_req),
    .addr        (ram_addr),
    .done        (ram_done),
    .data        (ram_rdata)
  );

  assign opcode  = opcode_q;
  assign operand = operand_q;
  assign pc      = pc_q;
  assign state   = state_q;
  assign alu_en  = alu_en_q;
  assign wb_en   = wb_en_q;
  assign wb_high = wb_high_q;
  assign halted  = halted_q;

endmodule

// File: tb/tb_cpuy_sequencer.sv
// Self-checking bench for cpuy_sequencer: directed scenarios plus random
// programs checked against an instruction-level reference model.
module tb_cpuy_sequencer;
  import cpuy_seq_pkg::*;

  // Decoder table bit positions.
  localparam int FAlu = 6, FMb = 5, FJmp = 4, FCond = 3, FMov = 2, FRam = 1, FDup = 0;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0;
  logic       halted, prog_req, prog_ack, ram_req, ram_ack;
  logic [7:0] prog_addr, prog_data, ram_addr, ram_data, opcode, operand, pc;
  logic       alu_operation, alu_multibyte_result, jump_operation, jump_condition;
  logic       mov_operation, ram_operand, duplicate_w, alu_en, wb_en, wb_high;
  logic [2:0] state;

  logic [7:0] prog_mem [256];
  logic [7:0] ram_mem  [256];
  logic [6:0] dec      [256];
  int         prog_wmin = 0, prog_wmax = 0, ram_wmin = 0, ram_wmax = 0;
  int         prog_cnt = 0, ram_cnt = 0;
  int         total = 0, bad = 0;
  logic       mon_en = 1'b0;
  logic [9:0] obs_q [$];

  always #5 clk = ~clk;

  cpuy_sequencer dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .run                  (run),
    .halted               (halted),
    .prog_req             (prog_req),
    .prog_addr            (prog_addr),
    .prog_data            (prog_data),
    .prog_ack             (prog_ack),
    .ram_req              (ram_req),
    .ram_addr             (ram_addr),
    .ram_data             (ram_data),
    .ram_ack              (ram_ack),
    .opcode               (opcode),
    .operand              (operand),
    .alu_operation        (alu_operation),
    .alu_multibyte_result (alu_multibyte_result),
    .jump_operation       (jump_operation),
    .jump_condition       (jump_condition),
    .mov_operation        (mov_operation),
    .ram_operand          (ram_operand),
    .duplicate_w          (duplicate_w),
    .alu_en               (alu_en),
    .wb_en                (wb_en),
    .wb_high              (wb_high),
    .pc                   (pc),
    .state                (state)
  );

  // Bench-side decoder and memories.
  assign alu_operation        = dec[opcode][FAlu];
  assign alu_multibyte_result = dec[opcode][FMb];
  assign jump_operation       = dec[opcode][FJmp];
  assign jump_condition       = dec[opcode][FCond];
  assign mov_operation        = dec[opcode][FMov];
  assign ram_operand          = dec[opcode][FRam];
  assign duplicate_w          = dec[opcode][FDup];
  assign prog_data = prog_mem[prog_addr];
  assign ram_data  = ram_mem[ram_addr];
  assign prog_ack  = prog_req && (prog_cnt == 0);
  assign ram_ack   = ram_req && (ram_cnt == 0);

  always @(posedge clk) begin
    if (!prog_req || prog_ack) prog_cnt <= int'($urandom_range(prog_wmax, prog_wmin));
    else                       prog_cnt <= prog_cnt - 1;
    if (!ram_req || ram_ack)   ram_cnt <= int'($urandom_range(ram_wmax, ram_wmin));
    else                       ram_cnt <= ram_cnt - 1;
  end

  // Strobe monitor: kind 1 = ALU, 2 = low writeback, 3 = high writeback.
  always @(negedge clk) begin
    if (mon_en) begin
      if (alu_en) obs_q.push_back({2'd1, operand});
      if (wb_en)  obs_q.push_back({wb_high ? 2'd3 : 2'd2, operand});
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_all();
    for (int i = 0; i < 256; i++) begin
      prog_mem[i] = 8'h00;
      ram_mem[i]  = 8'h00;
      dec[i]      = 7'b0;
    end
    prog_wmin = 0; prog_wmax = 0; ram_wmin = 0; ram_wmax = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    run = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    clear_all();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if ({prog_req, ram_req, alu_en, wb_en, wb_high, halted} !== 6'b0) begin
      bad++; $display("FAIL reset_strobes: got %b want 000000",
                      {prog_req, ram_req, alu_en, wb_en, wb_high, halted});
    end
    tick();
    rst_n = 1'b1;
    tick();
    total++;
    if ({pc, opcode, operand} !== 24'h0) begin
      bad++; $display("FAIL reset_regs: got %h want 000000", {pc, opcode, operand});
    end
    total++;
    if (state !== 3'(StIdle)) begin
      bad++; $display("FAIL reset_state: got %0d want %0d", state, StIdle);
    end
    tick();
    total++;
    if (prog_req !== 1'b0 || state !== 3'(StIdle)) begin
      bad++; $display("FAIL idle_no_run: req %b state %0d want 0 idle", prog_req, state);
    end
  endtask

  task automatic test_alu_basic();
    clear_all();
    prog_mem[0] = 8'h10; prog_mem[1] = 8'h05;
    dec[8'h10][FAlu] = 1'b1;
    do_reset();
    run = 1'b1;
    tick();
    run = 1'b0;
    total++;
    if (prog_req !== 1'b1 || prog_addr !== 8'h00) begin
      bad++; $display("FAIL alu_c1_fetch: req %b addr %h want 1 00", prog_req, prog_addr);
    end
    tick();
    total++;
    if (prog_req !== 1'b1 || prog_addr !== 8'h01) begin
      bad++; $display("FAIL alu_c2_fetch: req %b addr %h want 1 01", prog_req, prog_addr);
    end
    tick();
    total++;
    if (pc !== 8'h02 || alu_en !== 1'b0) begin
      bad++; $display("FAIL alu_c3: pc %h alu_en %b want 02 0", pc, alu_en);
    end
    tick();
    total++;
    if (alu_en !== 1'b1 || operand !== 8'h05 || wb_en !== 1'b0) begin
      bad++; $display("FAIL alu_c4: alu_en %b operand %h wb_en %b want 1 05 0",
                      alu_en, operand, wb_en);
    end
    tick();
    total++;
    if ({alu_en, wb_en, wb_high} !== 3'b010) begin
      bad++; $display("FAIL alu_c5: alu/wb/hi %b want 010", {alu_en, wb_en, wb_high});
    end
    tick();
    total++;
    if (wb_en !== 1'b0 || state !== 3'(StIdle) || prog_req !== 1'b0 || pc !== 8'h02) begin
      bad++; $display("FAIL alu_c6: wb %b state %0d req %b pc %h want 0 idle 0 02",
                      wb_en, state, prog_req, pc);
    end
  endtask

  task automatic run_jump(input logic cond, input logic [7:0] want_pc);
    int wb_seen = 0;
    clear_all();
    prog_mem[0] = 8'h20; prog_mem[1] = 8'h40;
    dec[8'h20][FJmp] = 1'b1;
    dec[8'h20][FCond] = cond;
    do_reset();
    run = 1'b1;
    tick();
    run = 1'b0;
    for (int c = 2; c <= 7; c++) begin
      tick();
      if (wb_en) wb_seen++;
    end
    total++;
    if (pc !== want_pc || wb_seen != 0 || state !== 3'(StIdle)) begin
      bad++; $display("FAIL jump_cond%0d: pc %h wb %0d state %0d want %h 0 idle",
                      cond, pc, wb_seen, state, want_pc);
    end
  endtask

  task automatic test_jump();
    run_jump(1'b1, 8'h40);
    run_jump(1'b0, 8'h02);
  endtask

  task automatic test_ram_wait();
    int held = 0, alu_cyc = 0;
    logic [7:0] alu_val = 8'h00;
    clear_all();
    prog_mem[0] = 8'h30; prog_mem[1] = 8'h33;
    ram_mem[8'h33] = 8'hA5;
    dec[8'h30][FAlu] = 1'b1;
    dec[8'h30][FRam] = 1'b1;
    ram_wmin = 3; ram_wmax = 3;
    do_reset();
    run = 1'b1;
    tick();
    run = 1'b0;
    for (int c = 2; c <= 12; c++) begin
      tick();
      if (ram_req && ram_addr == 8'h33) held++;
      if (alu_en) begin alu_cyc = c; alu_val = operand; end
    end
    total++;
    if (held != 4) begin
      bad++; $display("FAIL ram_addr_hold: got %0d cycles want 4", held);
    end
    total++;
    if (alu_cyc != 8 || alu_val !== 8'hA5) begin
      bad++; $display("FAIL ram_exec: cycle %0d operand %h want 8 a5", alu_cyc, alu_val);
    end
  endtask

  task automatic test_multibyte();
    clear_all();
    prog_mem[0] = 8'h11; prog_mem[1] = 8'h07;
    dec[8'h11][FAlu] = 1'b1;
    dec[8'h11][FMb] = 1'b1;
    do_reset();
    run = 1'b1;
    tick();
    run = 1'b0;
    tick(); tick(); tick(); tick();
    total++;
    if ({wb_en, wb_high} !== 2'b10) begin
      bad++; $display("FAIL mb_first: wb/hi %b want 10", {wb_en, wb_high});
    end
    tick();
    total++;
    if ({wb_en, wb_high} !== 2'b11) begin
      bad++; $display("FAIL mb_second: wb/hi %b want 11", {wb_en, wb_high});
    end
    tick();
    total++;
    if ({wb_en, wb_high} !== 2'b00 || state !== 3'(StIdle)) begin
      bad++; $display("FAIL mb_after: wb/hi %b state %0d want 00 idle", {wb_en, wb_high}, state);
    end
  endtask

  task automatic test_wrap_halt();
    int guard = 0, req_seen = 0;
    clear_all();
    prog_mem[0] = 8'h20; prog_mem[1] = 8'hFF; prog_mem[8'hFF] = 8'h00;
    dec[8'h20][FJmp] = 1'b1;
    dec[8'h20][FCond] = 1'b1;
    do_reset();
    run = 1'b1;
    for (int c = 1; c <= 5; c++) tick();
    total++;
    if (prog_req !== 1'b1 || prog_addr !== 8'hFF) begin
      bad++; $display("FAIL wrap_fetch: req %b addr %h want 1 ff", prog_req, prog_addr);
    end
    tick(); tick();
    total++;
    if (pc !== 8'h01) begin
      bad++; $display("FAIL wrap_pc: got %h want 01", pc);
    end
    while (!halted && guard < 50) begin tick(); guard++; end
    total++;
    if (halted !== 1'b1 || pc !== 8'h03) begin
      bad++; $display("FAIL halt_reached: halted %b pc %h want 1 03", halted, pc);
    end
    for (int c = 0; c < 6; c++) begin
      tick();
      if (prog_req) req_seen++;
    end
    total++;
    if (req_seen != 0 || halted !== 1'b1) begin
      bad++; $display("FAIL halt_sticky: req cycles %0d halted %b want 0 1", req_seen, halted);
    end
    run = 1'b0;
  endtask

  task automatic test_run_drop();
    int wb_seen = 0, req_late = 0;
    clear_all();
    prog_mem[0] = 8'h10; prog_mem[1] = 8'h05; prog_mem[2] = 8'h10; prog_mem[3] = 8'h06;
    dec[8'h10][FAlu] = 1'b1;
    do_reset();
    run = 1'b1;
    tick();
    tick();
    run = 1'b0;
    for (int c = 3; c <= 10; c++) begin
      tick();
      if (wb_en) wb_seen++;
      if (c >= 6 && prog_req) req_late++;
    end
    total++;
    if (wb_seen != 1 || req_late != 0 || state !== 3'(StIdle) || pc !== 8'h02) begin
      bad++; $display("FAIL run_drop: wb %0d late_req %0d state %0d pc %h want 1 0 idle 02",
                      wb_seen, req_late, state, pc);
    end
  endtask

  task automatic test_reset_mid_ram();
    clear_all();
    prog_mem[0] = 8'h30; prog_mem[1] = 8'h44;
    dec[8'h30][FAlu] = 1'b1;
    dec[8'h30][FRam] = 1'b1;
    ram_wmin = 10; ram_wmax = 10;
    do_reset();
    run = 1'b1;
    tick();
    run = 1'b0;
    tick(); tick(); tick(); tick();
    total++;
    if (ram_req !== 1'b1) begin
      bad++; $display("FAIL rst_ram_pending: ram_req %b want 1", ram_req);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({prog_req, ram_req, alu_en, wb_en, wb_high, halted} !== 6'b0 ||
        {pc, opcode, operand} !== 24'h0 || state !== 3'(StIdle)) begin
      bad++; $display("FAIL rst_mid_ram: strobes %b regs %h state %0d want 0 0 idle",
                      {prog_req, ram_req, alu_en, wb_en, wb_high, halted},
                      {pc, opcode, operand}, state);
    end
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) tick();
    total++;
    if (ram_req !== 1'b0 || state !== 3'(StIdle) || operand !== 8'h00) begin
      bad++; $display("FAIL rst_late_ack: ram_req %b state %0d operand %h want 0 idle 00",
                      ram_req, state, operand);
    end
  endtask

  // Random forward-only programs ending in HALT, checked at instruction level.
  task automatic test_random(input int iter);
    int         n, cyc, sum;
    logic [6:0] f;
    logic [7:0] mpc, op, arg, val;
    logic [9:0] exp_q [$];
    logic [9:0] got;
    clear_all();
    if (iter % 2 == 1) begin prog_wmax = 2; ram_wmax = 2; end
    for (int i = 0; i < 255; i++) begin
      f = 7'($urandom);
      if (f[FJmp]) f[FRam] = 1'b0;
      dec[i] = f;
    end
    for (int i = 0; i < 256; i++) ram_mem[i] = 8'($urandom);
    n = int'($urandom_range(12, 6));
    for (int i = 0; i < n; i++) begin
      op = 8'($urandom_range(254, 0));
      prog_mem[2*i] = op;
      if (dec[op][FJmp]) prog_mem[2*i+1] = 8'(2 * $urandom_range(n, i + 1));
      else               prog_mem[2*i+1] = 8'($urandom);
    end
    prog_mem[2*n] = HaltOpcodeDefault;
    mpc = 8'h00;
    sum = 0;
    forever begin
      op  = prog_mem[mpc];
      arg = prog_mem[8'(mpc + 8'd1)];
      mpc = mpc + 8'd2;
      if (op == HaltOpcodeDefault) break;
      f   = dec[op];
      val = f[FRam] ? ram_mem[arg] : arg;
      sum += 4 + (f[FRam] ? 1 : 0);
      if (f[FJmp]) begin
        if (f[FCond]) mpc = val;
      end else if (f[FAlu] || f[FMov]) begin
        if (f[FAlu]) exp_q.push_back({2'd1, val});
        exp_q.push_back({2'd2, val});
        sum += 1;
        if (f[FMb] || f[FDup]) begin
          exp_q.push_back({2'd3, val});
          sum += 1;
        end
      end
    end
    do_reset();
    obs_q.delete();
    mon_en = 1'b1;
    run = 1'b1;
    cyc = 0;
    while (!halted && cyc < 3000) begin tick(); cyc++; end
    mon_en = 1'b0;
    run = 1'b0;
    total++;
    if (halted !== 1'b1) begin
      bad++; $display("FAIL rnd%0d_timeout: no halt after %0d cycles", iter, cyc);
    end
    total++;
    if (pc !== mpc) begin
      bad++; $display("FAIL rnd%0d_pc: got %h want %h", iter, pc, mpc);
    end
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++; $display("FAIL rnd%0d_events: got %0d want %0d", iter, obs_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
      got = obs_q[k];
      total++;
      if (got !== exp_q[k]) begin
        bad++; $display("FAIL rnd%0d_ev%0d: got %h want %h", iter, k, got, exp_q[k]);
      end
    end
    if (iter % 2 == 0) begin
      total++;
      if (cyc != sum + 4) begin
        bad++; $display("FAIL rnd%0d_latency: got %0d want %0d", iter, cyc, sum + 4);
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu_basic();
    test_jump();
    test_ram_wait();
    test_multibyte();
    test_wrap_halt();
    test_run_drop();
    test_reset_mid_ram();
    for (int it = 0; it < 8; it++) test_random(it);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpuy_sequencer.md
# cpuy_sequencer

Instruction sequencer for the cpuy 8-bit core.
- Fetches two-byte instructions (opcode, operand) from program memory and presents the opcode to the `ucode` decoder.
- Resolves RAM operands and manages the PC, including taken/not-taken jumps.
- Issues ALU-enable and register-writeback strobes.
- Sits between program/data memory and the datapath; it is the only block that changes `opcode` or `pc`.

## Interface

Parameters:
- `PC_WIDTH`, default 8: program counter / program address width.
- `HALT_OPCODE`, default 8'hFF: opcode that stops the sequencer.

Ports:
- `clk`  in  1  sole clock, all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `run`  in  1  level; high permits instruction issue.
- `halted`  out  1  high while in HALT.
- `prog_req`  out  1  program-memory read request.
- `prog_addr`  out  PC_WIDTH  program read address.
- `prog_data`  in  8  program read data.
- `prog_ack`  in  1  program read complete.
- `ram_req`  out  1  data-RAM read request.
- `ram_addr`  out  8  RAM read address.
- `ram_data`  in  8  RAM read data.
- `ram_ack`  in  1  RAM read complete.
- `opcode`  out  8  latched opcode, drives the decoder.
- `operand`  out  8  latched operand, or the RAM value when `ram_operand` is set.
- `alu_operation`, `alu_multibyte_result`, `jump_operation`, `jump_condition`, `mov_operation`, `ram_operand`, `duplicate_w`  in  1 each  decoder flags.
- `alu_en`  out  1  one-cycle ALU strobe.
- `wb_en`  out  1  one-cycle writeback strobe.
- `wb_high`  out  1  qualifies `wb_en` as the second (high/duplicate) byte.
- `pc`  out  PC_WIDTH  current program counter.
- `state`  out  3  FSM state, for debug.

## Operation

States: IDLE, FETCH_OP, FETCH_ARG, DECODE, RAM_RD, EXEC, WB, WB_HI, HALT. Transitions:
- IDLE: go to FETCH_OP when `run`=1.
- FETCH_OP: `prog_req`=1 with `prog_addr`=`pc`. On `prog_ack`: latch `opcode`, `pc`←`pc`+1, go to FETCH_ARG.
- FETCH_ARG: same handshake. On `prog_ack`: latch `operand`, `pc`←`pc`+1, go to DECODE.
- DECODE: decoder flags are valid here and stay valid until the next opcode latch.
  - `opcode`==HALT_OPCODE: go to HALT.
  - Else `ram_operand`: go to RAM_RD.
  - Else: go to EXEC.
- RAM_RD: `ram_req`=1 with `ram_addr`=`operand`. On `ram_ack`: `operand`←`ram_data`, go to EXEC.
- EXEC:
  - `jump_operation`: if `jump_condition`, `pc`←`operand[PC_WIDTH-1:0]` (zero-extended if PC_WIDTH>8). Then go to FETCH_OP if `run`, else IDLE. No writeback.
  - `alu_operation`: `alu_en`=1 this cycle, go to WB.
  - `mov_operation`: go to WB.
  - No flag set: treat as NOP, same exit as a jump.
- WB: `wb_en`=1. Go to WB_HI if `alu_multibyte_result` or `duplicate_w`; else go to FETCH_OP if `run`, else IDLE.
- WB_HI: `wb_en`=1, `wb_high`=1. Go to FETCH_OP if `run`, else IDLE.
- HALT: `halted`=1. Leaves only on reset.

Rules:
- `run` is sampled only at instruction boundaries (IDLE, end of EXEC/WB/WB_HI). Deasserting `run` mid-instruction completes that instruction.
- PC arithmetic is modulo 2^PC_WIDTH: the increment from all-ones wraps to 0, including in the middle of an instruction.

## Timing

- Reset (async assert, synchronous deassert handled upstream):
  - `state`=IDLE.
  - `pc`, `opcode`, `operand` = 0.
  - `prog_req`, `ram_req`, `alu_en`, `wb_en`, `wb_high`, `halted` = 0.
  - Reset mid-handshake drops `req` immediately; a late `ack` is ignored.
- Handshakes:
  - `req` rises on entry to the requesting state. `addr` is stable while `req`=1.
  - Data is captured on the edge where `req`&&`ack`. `req` is low the next cycle.
  - `ack` is legal in the same cycle `req` rises (zero-wait memory).
  - `ack` while `req`=0 is ignored.
- Latency with zero-wait memory:
  - Jump or NOP: 4 cycles.
  - ALU/mov: 5 cycles.
  - Add +1 for a RAM operand and +1 for a multibyte/duplicate result.
  - Each memory wait cycle adds 1.
- Outputs are registered: `alu_en`, `wb_en`, `wb_high` are high for exactly one cycle per occurrence.
- Decoder contract: flags are valid at most one cycle after `opcode` changes.

## Structure

- Package `cpuy_seq_pkg`: state enum (3-bit encoding), HALT_OPCODE default, instruction length constant (2).
- Sub-module `seq_mem_port`: one generic req/ack read handshaker, instantiated twice (program, RAM).
- FSM and PC live in the top module.

## Test plan

- Reset, then `run`=1, zero-wait program {0x10,0x05}, decoder `alu_operation`=1 → `prog_addr` 0 then 1; `alu_en` in cycle 4; `wb_en` in cycle 5; `pc`=2.
- Jump {0x20,0x40} with `jump_condition`=1 → `pc`=0x40, no `wb_en`. Repeat with `jump_condition`=0 → `pc`=2.
- `ram_operand`=1, operand 0x33, `ram_ack` delayed 3 cycles, `ram_data`=0xA5 → `ram_addr`=0x33 held for 4 cycles; `operand`=0xA5 in EXEC.
- `alu_multibyte_result`=1 → `wb_en` for two consecutive cycles, `wb_high`=0 then 1.
- `pc`=0xFF, opcode at 0xFF, operand at 0x00 → `pc` wraps to 0x01. Then HALT_OPCODE → `halted`=1, no further `prog_req`.
- Drop `run` during FETCH_ARG → instruction completes, FSM parks in IDLE. Assert `rst_n`=0 during a RAM wait → all outputs at reset values within the same cycle.
